// File: rtl/hazard_unit.sv
// hazard_unit: load-use hazard detector with saturating stall-cycle counter
module hazard_unit #(
    parameter int OPCODE_6_4    = 3,
    parameter int WIDTH_SOURCE  = 5,
    parameter int CNT_WIDTH     = 16
) (
    input  logic                    CLK,
    input  logic                    rst_n,
    input  logic [WIDTH_SOURCE-1:0] IF_ID_rs1,
    input  logic [WIDTH_SOURCE-1:0] IF_ID_rs2,
    input  logic [OPCODE_6_4-1:0]   opcode,
    input  logic [WIDTH_SOURCE-1:0] ID_EX_Reg_rd,
    input  logic                    ID_EX_MEM_Rd,
    output logic                    PC_Stall,
    output logic                    IF_ID_Stall,
    output logic                    Mux_Sel_Flush,
    output logic [CNT_WIDTH-1:0]    Stall_Cnt
);
    logic                 w_uses_rs1;
    logic                 w_uses_rs2;
    logic                 w_hazard;
    logic [CNT_WIDTH-1:0] r_cnt;
    always_comb begin
        w_uses_rs2 = opcode == OPCODE_6_4'(2) || opcode == OPCODE_6_4'(3) || opcode == OPCODE_6_4'(6);
        w_uses_rs1 = w_uses_rs2 || opcode == OPCODE_6_4'(0) || opcode == OPCODE_6_4'(1);
        w_hazard   = rst_n && ID_EX_MEM_Rd && (ID_EX_Reg_rd != '0) &&
                     ((w_uses_rs1 && IF_ID_rs1 == ID_EX_Reg_rd) || (w_uses_rs2 && IF_ID_rs2 == ID_EX_Reg_rd));
    end
    always_ff @(posedge CLK or negedge rst_n) begin
        if (!rst_n)
            r_cnt <= '0;
        else if (w_hazard && r_cnt != '1)
            r_cnt <= r_cnt + 1'b1;
    end
    assign PC_Stall      = w_hazard;
    assign IF_ID_Stall   = w_hazard;
    assign Mux_Sel_Flush = w_hazard;
    assign Stall_Cnt     = r_cnt;
endmodule

// File: tb/tb_hazard_unit.sv
// tb_hazard_unit: scoreboard bench for hazard_unit (16-bit and 4-bit counter instances)
module tb_hazard_unit;
    logic        clk = 0;
    logic        rst_n = 0;
    logic [4:0]  rs1 = 0, rs2 = 0, rd = 0;
    logic [2:0]  op = 0;
    logic        mem = 0;
    logic        pc_a, ifid_a, fl_a, pc_b, ifid_b, fl_b;
    logic [15:0] cnt_a;
    logic [3:0]  cnt_b;
    int          n_vec = 0, n_err = 0;
    logic [15:0] m16 = 0;
    logic [3:0]  m4 = 0;

    typedef struct {
        logic        h;
        logic [15:0] c16;
        logic [3:0]  c4;
    } exp_t;
    exp_t sb[$];

    always #5 clk = ~clk;

    hazard_unit u_dut (
        .CLK(clk), .rst_n(rst_n), .IF_ID_rs1(rs1), .IF_ID_rs2(rs2), .opcode(op),
        .ID_EX_Reg_rd(rd), .ID_EX_MEM_Rd(mem),
        .PC_Stall(pc_a), .IF_ID_Stall(ifid_a), .Mux_Sel_Flush(fl_a), .Stall_Cnt(cnt_a)
    );

    hazard_unit #(.CNT_WIDTH(4)) u_sat (
        .CLK(clk), .rst_n(rst_n), .IF_ID_rs1(rs1), .IF_ID_rs2(rs2), .opcode(op),
        .ID_EX_Reg_rd(rd), .ID_EX_MEM_Rd(mem),
        .PC_Stall(pc_b), .IF_ID_Stall(ifid_b), .Mux_Sel_Flush(fl_b), .Stall_Cnt(cnt_b)
    );

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_vec++;
        if (got !== exp) begin
            n_err++;
            $display("FAIL %s got=%0h exp=%0h", tag, got, exp);
        end
    endtask

    function automatic logic ref_haz(input logic m, input logic [2:0] o, input logic [4:0] d,
                                     input logic [4:0] s1, input logic [4:0] s2);
        logic u1, u2;
        u1 = o inside {3'd0, 3'd1, 3'd2, 3'd3, 3'd6};
        u2 = o inside {3'd2, 3'd3, 3'd6};
        return m && d != 0 && ((u1 && s1 == d) || (u2 && s2 == d));
    endfunction

    task automatic apply(input logic m, input logic [2:0] o, input logic [4:0] d,
                         input logic [4:0] s1, input logic [4:0] s2);
        exp_t e, g;
        @(posedge clk);
        #1;
        mem = m; op = o; rd = d; rs1 = s1; rs2 = s2;
        e.h = ref_haz(m, o, d, s1, s2);
        e.c16 = m16;
        e.c4 = m4;
        sb.push_back(e);
        @(negedge clk);
        g = sb.pop_front();
        chk("pc_stall", 32'(pc_a), 32'(g.h));
        chk("ifid_stall", 32'(ifid_a), 32'(g.h));
        chk("mux_flush", 32'(fl_a), 32'(g.h));
        chk("stall_cnt16", 32'(cnt_a), 32'(g.c16));
        chk("sat_stall", 32'(pc_b), 32'(g.h));
        chk("stall_cnt4", 32'(cnt_b), 32'(g.c4));
        if (g.h && m16 != 16'hFFFF) m16++;
        if (g.h && m4 != 4'hF) m4++;
    endtask

    task automatic do_reset();
        #2;
        rst_n = 0;
        #1;
        chk("rst_pc", 32'(pc_a), 0);
        chk("rst_ifid", 32'(ifid_a), 0);
        chk("rst_flush", 32'(fl_a), 0);
        chk("rst_cnt16", 32'(cnt_a), 0);
        chk("rst_cnt4", 32'(cnt_b), 0);
        m16 = 0;
        m4 = 0;
        mem = 0;
        @(negedge clk);
        rst_n = 1;
    endtask

    initial begin
        mem = 1; op = 3'd6; rd = 5; rs1 = 5;
        #3;
        chk("init_pc", 32'(pc_a), 0);
        chk("init_cnt", 32'(cnt_a), 0);
        mem = 0;
        @(negedge clk);
        rst_n = 1;
        apply(0, 3'd6, 5, 5, 0);
        apply(0, 3'd6, 5, 5, 0);
        apply(1, 3'd6, 5, 5, 0);
        apply(1, 3'd6, 5, 5, 0);
        apply(1, 3'd6, 5, 5, 0);
        apply(1, 3'd6, 5, 3, 5);
        apply(1, 3'd6, 5, 3, 5);
        apply(1, 3'd1, 10, 10, 0);
        apply(1, 3'd1, 10, 3, 10);
        apply(1, 3'd3, 31, 31, 31);
        apply(1, 3'd7, 31, 31, 31);
        apply(1, 3'd3, 0, 0, 0);
        apply(1, 3'd0, 7, 7, 0);
        apply(1, 3'd0, 7, 1, 7);
        apply(1, 3'd3, 9, 9, 9);
        do_reset();
        apply(1, 3'd2, 4, 1, 4);
        apply(1, 3'd2, 4, 1, 4);
        apply(0, 3'd0, 0, 0, 0);
        for (int i = 0; i < 60; i++)
            apply(1'($urandom_range(0, 3) != 0), 3'($urandom), 5'($urandom_range(0, 3)),
                  5'($urandom_range(0, 3)), 5'($urandom_range(0, 3)));
        apply(1, 3'd3, 9, 9, 9);
        do_reset();
        for (int i = 0; i < 20; i++)
            apply(1, 3'd6, 12, 12, 1);
        apply(0, 3'd6, 12, 12, 1);
        chk("sat_final4", 32'(cnt_b), 15);
        chk("final16", 32'(cnt_a), 20);
        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end
endmodule
